pe_arr_drain: RTL
=================

# pe_arr_drain

Result drain stage directly downstream of the systolic PE array. On a `capture` pulse it snapshots all `rows*cols` 32-bit accumulator outputs of the array in a single cycle. It then streams them out one word per handshake, in row-major PE order, over a valid/ready interface. The array may start its next computation as soon as the snapshot is taken.

## Interface
Parameters
- `rows`, default 4: PE array rows; must match the array.
- `cols`, default 4: PE array columns; must match the array.
- Derived `N = rows*cols`; `IW = max(1, $clog2(N))`.

Ports
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `capture`, input, 1: snapshot request, sampled at the clock edge.
- `outs_port`, input, `[0:32*N-1]`: array results.
  - PE k (k = j + i*cols) occupies `outs_port[32*k : 32*(k+1)-1]`.
  - Index 0 is the leftmost slice, at the MSB end.
- `out_ready`, input, 1: downstream accepts a word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_data`, output, 32: snapshot word currently presented.
- `out_idx`, output, `IW`: PE index k of `out_data`.
- `out_last`, output, 1: high when `out_idx == N-1` and `out_valid` is high.
- `busy`, output, 1: drain in progress.
- `done`, output, 1: one-cycle pulse after the final word is accepted.
- `overrun`, output, 1: sticky flag; a capture was ignored.
- `clr_overrun`, input, 1: synchronous clear of `overrun`.

## Operation
- State machine with two states, IDLE and DRAIN.
- **Reset** (`rstn`=0, asynchronous):
  - State goes to IDLE and the index counter to 0.
  - All snapshot words are cleared to 0.
  - `out_valid`, `out_data`, `out_idx`, `out_last`, `busy`, `done` and `overrun` all go to 0.
- **IDLE:**
  - `capture`=1 copies all N words from `outs_port` into the snapshot registers, sets idx=0 and moves to DRAIN.
  - `capture`=0 leaves the state unchanged.
- **DRAIN:**
  - `out_valid`=1, `busy`=1, `out_data`=snap[idx], `out_idx`=idx.
  - A handshake is a cycle with `out_valid`=1 and `out_ready`=1.
  - On a handshake with idx<N-1: idx increments by 1.
  - On a handshake with idx==N-1: move to IDLE, and `done`=1 for exactly the next cycle.
  - With `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable; no word is skipped or repeated.
- **Capture while in DRAIN** is ignored. This includes the cycle of the final handshake.
  - The snapshot is unchanged.
  - `overrun` is set to 1 on the next edge.
- **`overrun`:**
  - Cleared only by reset or by `clr_overrun`=1.
  - If a set and `clr_overrun` occur in the same cycle, the set wins.
- **Snapshot registers** load only on an accepted capture. They are otherwise independent of `outs_port`, so the array may change its outputs freely during DRAIN.
- **Arithmetic:**
  - The data path is a pure copy with no width change.
  - idx never exceeds N-1, with no wrap-around inside a drain.
  - idx returns to 0 on the next accepted capture.
- **N=1:** the single word is asserted with `out_last`=1 immediately.

## Timing
- An accepted capture at edge t gives `out_valid`=1 and `busy`=1 from edge t onward, i.e. visible in cycle t+1, presenting word 0.
- All outputs are registered; there is no combinational path from `capture` or `out_ready` to any output.
- Throughput is 1 word/cycle with `out_ready` held high: N words over N consecutive cycles.
- With `out_ready` tied high and capture at edge t:
  - The final handshake is in cycle t+N.
  - `out_valid` and `busy` drop, and `done`=1, in cycle t+N+1.
  - The earliest next accepted capture is at edge t+N+1.
- `done` and `out_valid` are never high in the same cycle.
- Asserting reset mid-drain aborts the drain immediately. No `done` pulse is produced, and the state after release is IDLE.

## Test plan
Use rows=cols=4, N=16, and drive word k of `outs_port` as 0x1000+k unless noted.

1. **Basic drain.** Reset, then pulse `capture` with `out_ready`=1.
   - Expect 16 consecutive words 0x1000..0x100F with `out_idx` 0..15.
   - Expect `out_last` only on idx 15.
   - Expect `done` in the cycle after, and `busy` low afterwards.
2. **Backpressure.** Toggle `out_ready` as 1,0,0,1,... during a drain.
   - `out_data` and `out_idx` hold stable while `out_ready` is low.
   - The full ordered sequence is received exactly once.
3. **Snapshot isolation.** Change `outs_port` to all 0xDEADBEEF one cycle after capture.
   - The drained data is still 0x1000+k.
4. **Overrun.**
   - Pulse `capture` at idx 5: the output sequence is unaffected and `overrun`=1 from the next cycle.
   - Pulse `capture` on the final-handshake cycle: also ignored.
   - With set and clear in the same cycle, `overrun` stays 1; a later `clr_overrun` returns it to 0.
5. **Reset mid-drain.** Assert `rstn`=0 at idx 7.
   - All outputs go to 0 asynchronously.
   - A capture after release of word k = 0x2000+k drains 0x2000..0x200F from idx 0.
6. **Back-to-back captures.** Capture again on the cycle `done` is high.
   - The new drain starts the next cycle at idx 0 with no overrun.

Source files
------------

// File: rtl/pe_arr_drain.sv
// Drain stage behind the systolic PE array: snapshots all N accumulator words in one cycle,
// then streams them out in row-major order over a registered valid/ready port.
module pe_arr_drain #(
    parameter int rows = 4,
    parameter int cols = 4,
    localparam int N  = rows * cols,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              capture,
    input  logic [0:32*N-1]   outs_port,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [IW-1:0]     out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    input  logic              clr_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE      = IW'(1);

    // state_q is the observable FSM state; valid_q mirrors (state_q == DRAIN) as a flop.
    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   snap_q [N];
    logic [31:0]   data_q;
    logic          valid_q;
    logic          last_q;
    logic          done_q;
    logic          overrun_q;

    // Handshake: out_valid is high exactly while draining, so a transfer is
    // any DRAIN cycle with out_ready high; the producer never withdraws a word.
    logic          hs_d;
    logic          hs_last_d;
    logic [IW-1:0] idx_d;

    always_comb begin
        hs_d      = (state_q == DRAIN) && out_ready;
        hs_last_d = hs_d && (idx_q == LAST_IDX);
        idx_d     = idx_q + ONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            done_q <= hs_last_d;

            // A capture seen while draining (final handshake cycle included) is dropped.
            if (capture && (state_q == DRAIN)) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < N; k++) begin
                            snap_q[k] <= outs_port[32*k +: 32];
                        end
                        state_q <= DRAIN;
                        idx_q   <= '0;
                        data_q  <= outs_port[0 +: 32];
                        valid_q <= 1'b1;
                        last_q  <= (N == 1);
                    end
                end
                DRAIN: begin
                    if (hs_last_d) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (hs_d) begin
                        idx_q  <= idx_d;
                        data_q <= snap_q[idx_d];
                        last_q <= (idx_d == LAST_IDX);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
